// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - single-transfer SPI master with per-transfer mode, length and slave select
//
// Purpose:
//   Runs one SPI transaction per accepted start: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//   The mode, length, slave, bit order and tx word are latched when start is accepted
//   and stay fixed until the transfer ends. Received bits come back right-aligned.
//   Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input. When it is
//   defined, tx_data is right-aligned and bits shift out and back in LSB first.
//   When it is undefined the port is absent and transfers are MSB first only.
//
// Ports:
//   clk, rst_n          system clock (rising edge), synchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   slave_addr          target chip select; values >= NSLAVES are rejected with err
//   len                 bits to transfer; 0 or > DWIDTH means DWIDTH
//   cpol, cpha          SPI mode for this transfer
//   tx_data             transmit word (MSB-aligned, or right-aligned when LSB first)
//   lsb_first           (SPI_LSB_FIRST_EN only) LSB-first bit order
//   rx_data             received bits in [len-1:0], upper bits 0
//   busy, done, err     status; done and err are single-cycle pulses
//   sclk, mosi, miso    serial clock and data lines
//   cs_n                active-low chip selects, one per slave

module spi_master_ctrl #(
  parameter int DWIDTH       = 32,
  parameter int NSLAVES      = 4,
  parameter int S_ADDR_WIDTH = $clog2(NSLAVES),
  parameter int CLK_DIV      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [S_ADDR_WIDTH-1:0]     slave_addr,
  input  logic [$clog2(DWIDTH+1)-1:0] len,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic [DWIDTH-1:0]           tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic                        lsb_first,
`endif
  output logic [DWIDTH-1:0]           rx_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic [NSLAVES-1:0]          cs_n
);

  localparam int LW    = $clog2(DWIDTH + 1);
  localparam int EW    = $clog2(2 * DWIDTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [LW-1:0]    DW_LEN   = LW'(DWIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [S_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]           len_q, len_d;
  logic                    cpol_q, cpol_d;
  logic                    cpha_q, cpha_d;
  logic [DWIDTH-1:0]       shreg_q, shreg_d;
  logic [DWIDTH-1:0]       rx_q, rx_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [EW-1:0]           edge_q, edge_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Bit order: fixed MSB-first unless the LSB-first option is built in.
  logic                    lsb_in;
`ifdef SPI_LSB_FIRST_EN
  logic                    lsb_q, lsb_d;
  assign lsb_in = lsb_first;
`else
  logic                    lsb_q;
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  logic [LW-1:0]           len_eff;
  logic                    addr_bad;
  logic                    first_bit;
  logic                    cur_bit;
  logic [DWIDTH-1:0]       shreg_sh;
  logic                    next_bit;
  logic [DWIDTH-1:0]       rx_ins_msb;
  logic [DWIDTH-1:0]       rx_ins_lsb;
  logic [DWIDTH-1:0]       rx_ins;
  logic [EW-1:0]           last_edge_idx;
  logic                    leading;
  logic [NSLAVES-1:0]      cs_n_c;

  assign len_eff   = ((len == '0) || (len > DW_LEN)) ? DW_LEN : len;
  assign addr_bad  = (32'(slave_addr) >= 32'(NSLAVES));
  assign first_bit = lsb_in ? tx_data[0] : tx_data[DWIDTH-1];
  assign cur_bit   = lsb_q ? shreg_q[0] : shreg_q[DWIDTH-1];
  assign shreg_sh  = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign next_bit  = lsb_q ? shreg_sh[0] : shreg_sh[DWIDTH-1];

  // MSB-first: shift in at bit 0 so the first bit ends up at [len-1].
  // LSB-first: insert at [len-1] and shift right so the first bit ends up at [0].
  assign rx_ins_msb = {rx_q[DWIDTH-2:0], miso};

  always_comb begin
    rx_ins_lsb = rx_q >> 1;
    for (int i = 0; i < DWIDTH; i++) begin
      if (32'(len_q) == 32'(i + 1)) begin
        rx_ins_lsb[i] = miso;
      end
    end
  end

  assign rx_ins = lsb_q ? rx_ins_lsb : rx_ins_msb;

  // XFER ends after edge index 2*len-1, the last trailing edge.
  assign last_edge_idx = (EW'(len_q) << 1) - EW'(1);
  assign leading       = ~edge_q[0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    div_d   = div_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    lsb_d   = lsb_q;
`endif

    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        if (start) begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d  = slave_addr;
            len_d   = len_eff;
            cpol_d  = cpol;
            cpha_d  = cpha;
`ifdef SPI_LSB_FIRST_EN
            lsb_d   = lsb_first;
`endif
            shreg_d = tx_data;
            rx_d    = '0;
            div_d   = '0;
            edge_d  = '0;
            sclk_d  = cpol;
            mosi_d  = first_bit;
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = XFER;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      XFER: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          if (leading) begin
            if (!cpha_q) begin
              rx_d = rx_ins;
            end else begin
              // Mode with cpha=1 drives data on the leading edge; the bit
              // already shown during SETUP is simply re-driven for bit 0.
              mosi_d = cur_bit;
            end
          end else begin
            shreg_d = shreg_sh;
            if (!cpha_q) begin
              mosi_d = next_bit;
            end else begin
              rx_d = rx_ins;
            end
          end
          if (edge_q == last_edge_idx) begin
            state_d = HOLD;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      shreg_q <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= lsb_d;
`endif
    end
  end

  // Chip select follows the state register so it drops in the SETUP cycle
  // and rises in the same cycle done pulses.
  always_comb begin
    cs_n_c = '1;
    if (state_q != IDLE) begin
      for (int i = 0; i < NSLAVES; i++) begin
        if (32'(addr_q) == 32'(i)) begin
          cs_n_c[i] = 1'b0;
        end
      end
    end
  end

  assign cs_n    = cs_n_c;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl with mosi looped to miso

module tb_spi_master_ctrl;

  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SAW = 3;
  localparam int CD  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [SAW-1:0] slave_addr;
  logic [5:0]     len;
  logic           cpol;
  logic           cpha;
  logic [DW-1:0]  tx_data;
  logic [DW-1:0]  rx_data;
  logic           busy;
  logic           done;
  logic           err;
  logic           sclk;
  logic           mosi;
  logic           miso;
  logic [NS-1:0]  cs_n;
`ifdef SPI_LSB_FIRST_EN
  logic           lsb_first;
`endif

  always #5 clk = ~clk;

  assign miso = mosi;

  spi_master_ctrl #(
    .DWIDTH(DW),
    .NSLAVES(NS),
    .S_ADDR_WIDTH(SAW),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .slave_addr(slave_addr),
    .len(len),
    .cpol(cpol),
    .cpha(cpha),
    .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_data(rx_data),
    .busy(busy),
    .done(done),
    .err(err),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .cs_n(cs_n)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rx;
    int          tog;
    logic [63:0] seq;
    logic [3:0]  cs;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; starts a transfer at once and monitors it cycle by cycle.
  // inject_at >= 0 pulses a conflicting start mid-transfer; abort_at >= 0 resets
  // after that many sclk toggles.
  task automatic run_xfer(input logic [2:0] sa, input logic [5:0] ln, input logic cp,
                          input logic ph, input logic lsb, input logic [31:0] tx,
                          input logic [31:0] exp_rx, input int exp_tog,
                          input logic [63:0] exp_seq, input logic [3:0] exp_cs,
                          input int inject_at, input int abort_at);
    exp_t        e;
    exp_t        got_e;
    int          tog = 0;
    logic [63:0] seq = '0;
    logic [3:0]  cs_first;
    bit          cs_ok = 1'b1;
    logic        sclk_p;
    bit          got = 1'b0;
    bit          aborted = 1'b0;
    bit          saw_done = 1'b0;
    e.rx = exp_rx; e.tog = exp_tog; e.seq = exp_seq; e.cs = exp_cs;
    if (abort_at < 0) sb.push_back(e);
    slave_addr = sa; len = ln; cpol = cp; cpha = ph; tx_data = tx; start = 1'b1;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lsb;
`else
    if (lsb) $display("lsb_first requested but option not built");
`endif
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {63'd0, busy}, 64'd1);
    cs_first = cs_n;
    sclk_p = sclk;
    for (int c = 0; c < 2000 && !got && !aborted; c++) begin
      @(negedge clk);
      if (c == inject_at) begin
        start = 1'b1; tx_data = 32'hFFFF_FFFF; slave_addr = 3'd3; len = 6'd4;
      end else begin
        start = 1'b0;
      end
      if (sclk !== sclk_p) begin
        if (((tog % 2) == 0) == (ph == 1'b0)) seq = {seq[62:0], mosi};
        tog++;
      end
      sclk_p = sclk;
      if (busy && (cs_n !== cs_first)) cs_ok = 1'b0;
      if (done) got = 1'b1;
      if (abort_at >= 0 && tog == abort_at) aborted = 1'b1;
    end
    if (aborted) begin
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_cs_n", {60'd0, cs_n}, 64'hF);
      check("abort_sclk", {63'd0, sclk}, 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_rx", {32'd0, rx_data}, 64'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      check("abort_no_done", {63'd0, saw_done}, 64'd0);
    end else if (abort_at >= 0) begin
      check("abort_tog_timeout", 64'd0, 64'd1);
    end else begin
      check("done_seen", {63'd0, got}, 64'd1);
      got_e = sb.pop_front();
      check("rx_data", {32'd0, rx_data}, {32'd0, got_e.rx});
      check("sclk_toggles", 64'(tog), 64'(got_e.tog));
      check("mosi_seq", seq, got_e.seq);
      check("cs_n_xfer", {60'd0, cs_first}, {60'd0, got_e.cs});
      check("cs_n_stable", {63'd0, cs_ok}, 64'd1);
      check("busy_at_done", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("done_width", {63'd0, done}, 64'd0);
      check("cs_n_idle", {60'd0, cs_n}, 64'hF);
      check("sclk_idle", {63'd0, sclk}, {63'd0, cp});
      check("mosi_idle", {63'd0, mosi}, 64'd0);
      check("rx_hold", {32'd0, rx_data}, {32'd0, got_e.rx});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; slave_addr = '0; len = '0; cpol = 1'b0; cpha = 1'b0;
    tx_data = '0;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs_n", {60'd0, cs_n}, 64'hF);
    check("rst_sclk", {63'd0, sclk}, 64'd0);
    check("rst_mosi", {63'd0, mosi}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_rx", {32'd0, rx_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // mode 0, slave 1, 8 bits
    run_xfer(3'd1, 6'd8, 1'b0, 1'b0, 1'b0, 32'hA500_0000, 32'h0000_00A5, 16,
             64'hA5, 4'b1101, -1, -1);
    // mode 3, len 0 means full word; back-to-back with the previous transfer
    run_xfer(3'd2, 6'd0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 64,
             64'hDEAD_BEEF, 4'b1011, -1, -1);
    // mode 2, 12 bits
    run_xfer(3'd0, 6'd12, 1'b1, 1'b0, 1'b0, 32'hC3A0_0000, 32'h0000_0C3A, 24,
             64'hC3A, 4'b1110, -1, -1);
    // len beyond DWIDTH is treated as DWIDTH
    run_xfer(3'd3, 6'd40, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'h8000_0001, 64,
             64'h8000_0001, 4'b0111, -1, -1);

    // out-of-range slave
    slave_addr = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {63'd0, err}, 64'd1);
    check("err_busy", {63'd0, busy}, 64'd0);
    check("err_cs_n", {60'd0, cs_n}, 64'hF);
    @(negedge clk);
    check("err_width", {63'd0, err}, 64'd0);
    check("err_busy2", {63'd0, busy}, 64'd0);

    // mode 1, 16 bits, conflicting start mid-transfer
    run_xfer(3'd0, 6'd16, 1'b0, 1'b1, 1'b0, 32'h1234_0000, 32'h0000_1234, 32,
             64'h1234, 4'b1110, 10, -1);
    repeat (20) @(negedge clk);
    check("no_extra_xfer", {63'd0, busy}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    // reset after 5 toggles
    run_xfer(3'd1, 6'd8, 1'b0, 1'b0, 1'b0, 32'h5A00_0000, 32'h0, 0,
             64'h0, 4'b1101, -1, 5);

`ifdef SPI_LSB_FIRST_EN
    // LSB first: mosi 1,1,0,0
    run_xfer(3'd1, 6'd4, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0003, 8,
             64'hC, 4'b1101, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, maximum transfer length in bits.
REQ-002 SHALL have parameter NSLAVES, default 4, number of chip selects.
REQ-003 SHALL have parameter S_ADDR_WIDTH, default $clog2(NSLAVES), slave select width.
REQ-004 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period (>=1).
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have ports start (in, 1, request pulse), slave_addr (in, S_ADDR_WIDTH, target), len (in, $clog2(DWIDTH+1), bits to send).
REQ-008 SHALL have ports cpol, cpha (in, 1 each, SPI mode) and tx_data (in, DWIDTH, MSB-aligned to len).
REQ-009 SHALL have ports rx_data (out, DWIDTH), busy (out, 1), done (out, 1), err (out, 1).
REQ-010 SHALL have ports sclk (out, 1), mosi (out, 1), miso (in, 1), cs_n (out, NSLAVES, active-low).

Function
REQ-011 SHALL implement states IDLE -> SETUP -> XFER -> HOLD -> IDLE.
REQ-012 SHALL, in IDLE with start=1, latch slave_addr, len, cpol, cpha, tx_data and enter SETUP next cycle; busy=1 from that cycle.
REQ-013 SHALL treat len=0 or len>DWIDTH as DWIDTH.
REQ-014 SHALL, if slave_addr>=NSLAVES, stay in IDLE, pulse err for 1 cycle, keep cs_n all high.
REQ-015 SHALL drive cs_n[slave_addr]=0 throughout SETUP, XFER, HOLD; all other bits 1.
REQ-016 SHALL hold SETUP for CLK_DIV cycles with sclk=cpol and mosi=first data bit.
REQ-017 SHALL in XFER toggle sclk every CLK_DIV cycles, 2*len toggles total, ending at sclk=cpol.
REQ-018 SHALL for cpha=0 sample miso on leading edges, update mosi on trailing edges; for cpha=1 update mosi on leading, sample on trailing.
REQ-019 SHALL hold HOLD for CLK_DIV cycles, then release cs_n, return to IDLE, pulse done 1 cycle in the same cycle busy falls.
REQ-020 SHALL present rx_data right-aligned (received len bits in [len-1:0], upper bits 0), stable from done until next start accepted.
REQ-021 SHALL ignore start while busy=1; latched parameters SHALL not change mid-transfer.
REQ-022 SHALL keep sclk=latched cpol in IDLE after the first transfer; mosi=0 in IDLE.
REQ-023 SHALL accept a start in the cycle after done (back-to-back), with cs_n high for at least that one cycle.

Reset
REQ-024 SHALL on rst_n=0 at clk edge set state IDLE, cs_n all 1, sclk 0, mosi 0, busy 0, done 0, err 0, rx_data 0.
REQ-025 SHALL abort an in-progress transfer on reset without pulsing done; partial rx data discarded.

Configuration
REQ-026 SHALL honour macro SPI_LSB_FIRST_EN: defined -> extra input lsb_first (1 bit, latched at start) selects LSB-first shift/receive with tx_data right-aligned; undefined -> port absent, MSB-first only.

Verification
REQ-027 SHALL cover: CLK_DIV=2, mode 0, slave 1, len=8, tx_data=0xA5000000, miso looped to mosi -> cs_n=4'b1101, 16 sclk toggles, rx_data=0x000000A5, done 1 cycle.
REQ-028 SHALL cover: mode 3, len=0, tx_data=0xDEADBEEF, loopback -> 32 bits sent, rx_data=0xDEADBEEF, sclk idles 1.
REQ-029 SHALL cover: slave_addr=4 with NSLAVES=4 -> err pulse, busy stays 0, cs_n=4'b1111.
REQ-030 SHALL cover: start pulsed mid-transfer with different tx_data -> ignored, first transfer completes unchanged.
REQ-031 SHALL cover: rst_n low after 5 sclk toggles -> next edge cs_n=4'b1111, sclk=0, busy=0, no done.
REQ-032 SHALL cover: with SPI_LSB_FIRST_EN, lsb_first=1, len=4, tx_data=0x3 -> mosi sequence 1,1,0,0.
